// File: rtl/cruise_pkg.sv
// Shared definitions for the cruise-control stage: FSM state encodings,
// setpoint update operations and default speed limits.
package cruise_pkg;

    // FSM states; the numeric values appear on the debug state output.
    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_CRUISE  = 3'd1,
        ST_ACCEL   = 3'd2,
        ST_COAST   = 3'd3,
        ST_STANDBY = 3'd4
    } cruise_state_e;

    // What happens to the stored setpoint in a given cycle.
    typedef enum logic [1:0] {
        SP_HOLD    = 2'd0,  // keep current setpoint
        SP_CAPTURE = 2'd1,  // take the current (pre-update) speed
        SP_TRACK   = 2'd2,  // follow the newly computed speed
        SP_CLEAR   = 2'd3   // forget the setpoint
    } setpoint_op_e;

    localparam int DEF_MAX_SPEED  = 200;
    localparam int DEF_MIN_CRUISE = 45;
    localparam int DEF_BRAKE_STEP = 2;

    // True for the states in which the cruise function is holding speed.
    function automatic logic is_cruise_state(cruise_state_e s);
        return (s == ST_CRUISE) || (s == ST_ACCEL) || (s == ST_COAST);
    endfunction

endpackage

// File: rtl/sat_step.sv
// Combinational saturating add/subtract of a step value. Additions clamp at
// hi_i, subtractions clamp at lo_i. All comparisons are done one bit wider
// than the operands so the result never wraps.
module sat_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] value_i,
    input  logic [W-1:0] step_i,
    input  logic         sub_i,
    input  logic [W-1:0] lo_i,
    input  logic [W-1:0] hi_i,
    output logic [W-1:0] result_o
);

    logic [W:0] sum;
    logic [W:0] floor_sum;

    // Widened add or floor-checked subtract, clamped to the active bound.
    always_comb begin
        sum       = {1'b0, value_i} + {1'b0, step_i};
        floor_sum = {1'b0, lo_i} + {1'b0, step_i};
        result_o  = value_i;
        if (sub_i) begin
            if ({1'b0, value_i} < floor_sum) begin
                result_o = lo_i;
            end else begin
                result_o = value_i - step_i;
            end
        end else begin
            if (sum > {1'b0, hi_i}) begin
                result_o = hi_i;
            end else begin
                result_o = sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/cruise_controller.sv
// Cruise-control stage: vehicle speed model, setpoint register and the
// OFF/CRUISE/ACCEL/COAST/STANDBY state machine. All outputs come from
// registers. Build option: define CRUISE_RESUME_EN to build STANDBY and
// the resume path; without it brake/cancel drop straight to OFF.
module cruise_controller
    import cruise_pkg::*;
#(
    parameter int SPEED_W    = 8,
    parameter int MAX_SPEED  = DEF_MAX_SPEED,
    parameter int MIN_CRUISE = DEF_MIN_CRUISE,
    parameter int BRAKE_STEP = DEF_BRAKE_STEP
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               throttle,
    input  logic               brake,
    input  logic               set,
    input  logic               accel,
    input  logic               coast,
    input  logic               cancel,
    input  logic               resume,
    output logic [SPEED_W-1:0] speed,
    output logic [SPEED_W-1:0] cruise_speed,
    output logic               cruise_on,
    output logic [2:0]         state
);

    localparam logic [SPEED_W-1:0] MAX_V   = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] MIN_V   = SPEED_W'(MIN_CRUISE);
    localparam logic [SPEED_W-1:0] BRAKE_V = SPEED_W'(BRAKE_STEP);
    localparam logic [SPEED_W-1:0] ONE_V   = SPEED_W'(1);

    cruise_state_e      state_q, state_d, state_nx;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [SPEED_W-1:0] cruise_q, cruise_d;

    // Speed-path operation selected by the FSM decision.
    logic [SPEED_W-1:0] step_sel, lo_sel, hi_sel, sat_res;
    logic               sub_sel;
    logic               set_ok;
    setpoint_op_e       sp_op;

`ifndef CRUISE_RESUME_EN
    // resume has no function in this build; the port is kept for interface stability.
    logic unused_resume;
    assign unused_resume = resume;
`endif

    sat_step #(.W(SPEED_W)) u_speed_step (
        .value_i  (speed_q),
        .step_i   (step_sel),
        .sub_i    (sub_sel),
        .lo_i     (lo_sel),
        .hi_i     (hi_sel),
        .result_o (sat_res)
    );

    // Decision logic: next state, speed operation and setpoint operation by input priority.
    always_comb begin
        state_nx = state_q;
        step_sel = '0;
        sub_sel  = 1'b0;
        lo_sel   = '0;
        hi_sel   = MAX_V;
        sp_op    = SP_HOLD;
        set_ok   = set && (speed_q >= MIN_V);

        case (state_q)
            ST_CRUISE, ST_ACCEL, ST_COAST: begin
                if (brake || cancel) begin
`ifdef CRUISE_RESUME_EN
                    state_nx = ST_STANDBY;
`else
                    state_nx = ST_OFF;
                    sp_op    = SP_CLEAR;
`endif
                end else if (accel) begin
                    state_nx = ST_ACCEL;
                    step_sel = ONE_V;
                    sp_op    = SP_TRACK;
                end else if (coast) begin
                    state_nx = ST_COAST;
                    step_sel = ONE_V;
                    sub_sel  = 1'b1;
                    lo_sel   = MIN_V;
                    sp_op    = SP_TRACK;
                end else begin
                    // Plain cruise: close the gap to the setpoint one unit per cycle.
                    state_nx = ST_CRUISE;
                    if (speed_q < cruise_q) begin
                        step_sel = ONE_V;
                    end else if (speed_q > cruise_q) begin
                        step_sel = ONE_V;
                        sub_sel  = 1'b1;
                    end
                end
            end
`ifdef CRUISE_RESUME_EN
            ST_STANDBY: begin
                if (!brake && !cancel) begin
                    if (set_ok) begin
                        state_nx = ST_CRUISE;
                        sp_op    = SP_CAPTURE;
                    end else if (resume) begin
                        state_nx = ST_CRUISE;
                    end else if (throttle) begin
                        step_sel = ONE_V;
                    end
                end
            end
`endif
            ST_OFF: begin
                if (!brake && !cancel) begin
                    if (set_ok) begin
                        state_nx = ST_CRUISE;
                        sp_op    = SP_CAPTURE;
                    end else if (throttle) begin
                        step_sel = ONE_V;
                    end
                end
            end
            default: begin
                state_nx = ST_OFF;
                sp_op    = SP_CLEAR;
            end
        endcase

        // Braking overrides every other speed update in every state.
        if (brake) begin
            step_sel = BRAKE_V;
            sub_sel  = 1'b1;
            lo_sel   = '0;
        end
    end

    // Next register values from the saturated speed result and setpoint operation.
    always_comb begin
        state_d  = state_nx;
        speed_d  = sat_res;
        cruise_d = cruise_q;
        case (sp_op)
            SP_CAPTURE: cruise_d = speed_q;
            SP_TRACK:   cruise_d = sat_res;
            SP_CLEAR:   cruise_d = '0;
            default:    cruise_d = cruise_q;
        endcase
`ifdef CRUISE_RESUME_EN
        // A vehicle braked to standstill forgets the setpoint and shuts off.
        if ((state_q == ST_STANDBY) && (state_nx == ST_STANDBY) && (sat_res == '0)) begin
            state_d  = ST_OFF;
            cruise_d = '0;
        end
`endif
    end

    // State, speed and setpoint registers with asynchronous clear.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q  <= ST_OFF;
            speed_q  <= '0;
            cruise_q <= '0;
        end else begin
            state_q  <= state_d;
            speed_q  <= speed_d;
            cruise_q <= cruise_d;
        end
    end

    assign speed        = speed_q;
    assign cruise_speed = cruise_q;
    assign cruise_on    = is_cruise_state(state_q);
    assign state        = state_q;

endmodule
